col_read_scheduler: RTL and testbench

Round-robin read scheduler for the 16 pixel-column readout chains of one sixteen-column group. It watches each column's pending-hit flag, issues a one-cycle read strobe to one column per cycle, and captures that column's 46-bit head word tagged with the column ID. It presents the captured word to the downstream global readout through a valid/ready handshake. It also enforces a one-cycle hold-off per column so a chain that has just been read can update its head word before it is read again.

---
 rtl/col_read_scheduler_if.sv | 25 ++
 rtl/col_read_scheduler.sv | 98 +++++++++
 tb/tb_col_read_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/col_read_scheduler_if.sv
// Column-side and downstream-side signals of the column read scheduler.
// The scheduler uses the slave view; whatever drives the column chains and consumes words uses master.
`timescale 1ns/1ps
interface col_read_scheduler_if #(
   parameter int NCOL      = 16,
   parameter int DATAWIDTH = 46,
   parameter int IDW       = $clog2(NCOL)
);
   logic [NCOL-1:0]           col_hit_chain;
   logic [NCOL*DATAWIDTH-1:0] col_data_chain;
   logic [NCOL-1:0]           col_read_chain;
   logic [IDW+DATAWIDTH-1:0]  out_data;
   logic                      out_valid;
   logic                      out_ready;

   modport slave (
      input  col_hit_chain, col_data_chain, out_ready,
      output col_read_chain, out_data, out_valid
   );

   modport master (
      output col_hit_chain, col_data_chain, out_ready,
      input  col_read_chain, out_data, out_valid
   );
endinterface

// File: rtl/col_read_scheduler.sv
// Round-robin read scheduler for one sixteen-column readout group: strobes one eligible
// column per cycle, captures its head word tagged with the column ID, and hands it downstream.
//   state  | meaning
//   IDLE   | nothing eligible and no word held
//   ACTIVE | grants possible
//   STALL  | word held and downstream not ready
`timescale 1ns/1ps
module col_read_scheduler #(
   parameter int NCOL      = 16,
   parameter int DATAWIDTH = 46,
   localparam int IDW      = $clog2(NCOL)
) (
   input  logic                 clk,
   input  logic                 rst,
   col_read_scheduler_if.slave  bus,
   input  logic [NCOL-1:0]      col_enable,
   input  logic                 sched_enable,
   input  logic                 clr_count,
   output logic [15:0]          read_count,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

   state_t                 state, state_nxt;
   logic [IDW-1:0]         last_col, grant_col, idx;
   logic [NCOL-1:0]        holdoff, eligible, grant_onehot;
   logic                   found, load_ok, grant, accept, out_valid_nxt;
   logic [DATAWIDTH-1:0]   words [NCOL];

   always_comb begin
      for (int c = 0; c < NCOL; c++)
         words[c] = bus.col_data_chain[c*DATAWIDTH +: DATAWIDTH];
   end

   assign eligible = bus.col_hit_chain & col_enable & ~holdoff & {NCOL{sched_enable}};
   assign load_ok  = ~bus.out_valid | bus.out_ready;
   assign accept   = bus.out_valid & bus.out_ready;

   // Search upward from last_col+1; the final step wraps back onto last_col itself.
   always_comb begin
      found     = 1'b0;
      grant_col = last_col;
      idx       = last_col;
      for (int i = 1; i <= NCOL; i++) begin
         idx = last_col + IDW'(i);
         if (!found && eligible[idx]) begin
            found     = 1'b1;
            grant_col = idx;
         end
      end
   end

   // Gated by rst so the strobe can never fire while the block is held in reset.
   assign grant              = found & load_ok & ~rst;
   assign grant_onehot       = grant ? (NCOL'(1) << grant_col) : '0;
   assign bus.col_read_chain = grant_onehot;
   assign out_valid_nxt      = grant | (bus.out_valid & ~accept);
   assign busy               = (state != IDLE);

   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: begin
            if (|eligible) state_nxt = ACTIVE;
         end
         default: begin
            if (bus.out_valid && !bus.out_ready)     state_nxt = STALL;
            else if (out_valid_nxt || (|eligible))   state_nxt = ACTIVE;
            else                                     state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_col      <= '1;
         holdoff       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         read_count    <= '0;
      end else begin
         state         <= state_nxt;
         holdoff       <= grant_onehot;
         bus.out_valid <= out_valid_nxt;
         if (grant) begin
            last_col     <= grant_col;
            bus.out_data <= {grant_col, words[grant_col]};
         end
         if (clr_count)
            read_count <= grant ? 16'd1 : 16'd0;
         else if (grant && read_count != 16'hFFFF)
            read_count <= read_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_col_read_scheduler.sv
// Directed-vector bench for col_read_scheduler with hand-computed expectations.
`timescale 1ns/1ps
module tb_col_read_scheduler;

   logic        clk;
   logic        rst;
   logic [15:0] col_enable;
   logic        sched_enable;
   logic        clr_count;
   logic [15:0] read_count;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [45:0] word_of [16];

   col_read_scheduler_if bus ();

   col_read_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .col_enable   (col_enable),
      .sched_enable (sched_enable),
      .clr_count    (clr_count),
      .read_count   (read_count),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #12.5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [49:0] exp_word(input int c);
      logic [3:0] id;
      id = 4'(c);
      return {id, word_of[c]};
   endfunction

   function automatic logic [15:0] onehot(input int c);
      logic [15:0] v;
      v = 16'd1;
      return v << c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst               = 1'b1;
      bus.col_hit_chain = '0;
      bus.out_ready     = 1'b1;
      col_enable        = 16'hFFFF;
      sched_enable      = 1'b1;
      clr_count         = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int c = 0; c < 16; c++) begin
         word_of[c] = 46'h155_0000_0000 + 46'(c) * 46'h1_0203_0405;
         if (c == 5) word_of[c] = 46'h0123456789A;
         bus.col_data_chain[c*46 +: 46] = word_of[c];
      end

      // reset state
      reset_dut();
      #1;
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_data",  64'(bus.out_data), 64'd0);
      check("rst_count", 64'(read_count), 64'd0);
      check("rst_busy",  64'(busy), 64'd0);
      check("rst_strobe", 64'(bus.col_read_chain), 64'd0);

      // single hit on column 5
      reset_dut();
      bus.col_hit_chain = 16'h0020;
      #1;
      check("single_strobe", 64'(bus.col_read_chain), 64'h0020);
      tick();
      bus.col_hit_chain = '0;
      check("single_data",  64'(bus.out_data), 64'({4'h5, 46'h0123456789A}));
      check("single_valid", 64'(bus.out_valid), 64'd1);
      check("single_count", 64'(read_count), 64'd1);
      #1;
      check("single_strobe_off", 64'(bus.col_read_chain), 64'd0);
      tick();
      check("single_drained", 64'(bus.out_valid), 64'd0);

      // all sixteen columns streaming
      reset_dut();
      bus.col_hit_chain = 16'hFFFF;
      for (int k = 0; k < 32; k++) begin
         #1;
         check("rr_strobe", 64'(bus.col_read_chain), 64'(onehot(k % 16)));
         tick();
         check("rr_data", 64'(bus.out_data), 64'(exp_word(k % 16)));
      end
      check("rr_count", 64'(read_count), 64'd32);

      // single column held high: holdoff gives alternate-cycle grants
      reset_dut();
      bus.col_hit_chain = 16'h0008;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("hold_strobe", 64'(bus.col_read_chain), (k % 2 == 0) ? 64'h8 : 64'h0);
         tick();
      end
      check("hold_count", 64'(read_count), 64'd5);

      // downstream stall with column 7 pending
      reset_dut();
      bus.out_ready     = 1'b0;
      bus.col_hit_chain = 16'h0080;
      #1;
      check("stall_first_strobe", 64'(bus.col_read_chain), 64'h80);
      tick();
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      for (int k = 0; k < 3; k++) begin
         #1;
         check("stall_strobe", 64'(bus.col_read_chain), 64'd0);
         check("stall_busy",   64'(busy), 64'd1);
         check("stall_data",   64'(bus.out_data), 64'(exp_word(7)));
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("stall_release_strobe", 64'(bus.col_read_chain), 64'h80);
      tick();
      check("stall_release_data",  64'(bus.out_data), 64'(exp_word(7)));
      check("stall_release_valid", 64'(bus.out_valid), 64'd1);
      check("stall_release_count", 64'(read_count), 64'd2);

      // column 0 masked, then global disable drains the output
      reset_dut();
      col_enable        = 16'hFFFE;
      bus.col_hit_chain = 16'hFFFF;
      for (int k = 0; k < 20; k++) begin
         #1;
         check("mask_strobe", 64'(bus.col_read_chain), 64'(onehot((k % 15) + 1)));
         tick();
      end
      sched_enable = 1'b0;
      #1;
      check("sched_off_strobe", 64'(bus.col_read_chain), 64'd0);
      check("sched_off_valid",  64'(bus.out_valid), 64'd1);
      tick();
      check("sched_off_drained", 64'(bus.out_valid), 64'd0);
      check("sched_off_hold",    64'(bus.out_data), 64'(exp_word(5)));

      // reset pulse mid-stream
      reset_dut();
      bus.col_hit_chain = 16'hFFFF;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check("midrst_valid",  64'(bus.out_valid), 64'd0);
      check("midrst_strobe", 64'(bus.col_read_chain), 64'd0);
      check("midrst_count",  64'(read_count), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("midrst_first_grant", 64'(bus.col_read_chain), 64'h1);

      // counter saturation and clear with coincident grant
      reset_dut();
      bus.col_hit_chain = 16'hFFFF;
      repeat (65540) tick();
      check("sat_count", 64'(read_count), 64'hFFFF);
      clr_count = 1'b1;
      #1;
      check("clr_grant_present", 64'(|bus.col_read_chain), 64'd1);
      tick();
      clr_count = 1'b0;
      check("clr_with_grant", 64'(read_count), 64'd1);
      sched_enable = 1'b0;
      clr_count    = 1'b1;
      tick();
      clr_count = 1'b0;
      check("clr_no_grant", 64'(read_count), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
